// File: rtl/ext_int_filter_pkg.sv
// Shared constants and types for the external interrupt filter.
// Holds the register address table and the per-line debounce state type.
package ext_int_filter_pkg;

  localparam int NUM_LINES = 9;

  localparam logic [3:0] ADDR_PLR    = 4'h0;
  localparam logic [3:0] ADDR_DBR    = 4'h1;
  localparam logic [3:0] ADDR_STATUS = 4'h2;

  typedef enum logic [1:0] {
    stLow     = 2'd0,
    stRiseChk = 2'd1,
    stHigh    = 2'd2,
    stFallChk = 2'd3
  } lineState_t;

endpackage

// File: rtl/ext_int_filter_if.sv
// Register access bus of the external interrupt filter.
// The bus owner uses the master modport, the filter block uses the slave modport.
interface ext_int_filter_if;
  logic        IO_WrEn;
  logic [31:0] IO_WrData;
  logic [3:0]  IO_RegAddress;
  logic        IO_BlockSelect;
  logic [31:0] IO_RdData;

  modport master (
    output IO_WrEn, IO_WrData, IO_RegAddress, IO_BlockSelect,
    input  IO_RdData
  );

  modport slave (
    input  IO_WrEn, IO_WrData, IO_RegAddress, IO_BlockSelect,
    output IO_RdData
  );
endinterface

// File: rtl/ext_int_filter_line_debouncer.sv
// One interrupt line: two-flop synchronizer, polarity fix-up, then debounce.
// The debounce FSM exists only with EXT_INT_DEBOUNCE_EN; otherwise the line is a plain registered copy.
module ext_int_filter_line_debouncer
  import ext_int_filter_pkg::*;
#(
  parameter int DBC_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             pin,
  input  logic             polarity,
  input  logic [DBC_W-1:0] dbr,
  output logic             level
);

  logic syncA;
  logic syncB;
  logic cond;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
    end else begin
      syncA <= pin;
      syncB <= syncA;
    end
  end

  assign cond = syncB ^ polarity;

`ifdef EXT_INT_DEBOUNCE_EN
  lineState_t       state;
  logic [DBC_W-1:0] cnt;

  // The compare uses >= so a DBR lowered below a running count completes at once.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= stLow;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        stLow: begin
          if (cond) begin
            state <= stRiseChk;
            cnt   <= '0;
          end
        end
        stHigh: begin
          if (!cond) begin
            state <= stFallChk;
            cnt   <= '0;
          end
        end
        stRiseChk: begin
          if (!cond) begin
            state <= stLow;
          end else if (cnt >= dbr) begin
            state <= stHigh;
            level <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        stFallChk: begin
          if (cond) begin
            state <= stHigh;
          end else if (cnt >= dbr) begin
            state <= stLow;
            level <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= stLow;
      endcase
    end
  end
`else
  logic unusedDbr;
  assign unusedDbr = ^dbr;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      level <= 1'b0;
    end else begin
      level <= cond;
    end
  end
`endif

endmodule

// File: rtl/ext_int_filter.sv
// External interrupt filter: 8 IRQ pins plus one urgent pin, each synchronized, polarity-adjusted and filtered.
// Debouncing and the DBR register are present only when EXT_INT_DEBOUNCE_EN is defined.
module ext_int_filter
  import ext_int_filter_pkg::*;
#(
  parameter int DBC_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [7:0]       PinIrq,
  input  logic             PinUrq,
  ext_int_filter_if.slave  io,
  output logic [7:0]       IntReq,
  output logic             UrgentReq
);

  logic [NUM_LINES-1:0] plr;
  logic [DBC_W-1:0]     dbr;
  logic [NUM_LINES-1:0] pins;
  logic [NUM_LINES-1:0] lineLevel;
  logic                 wrHit;
  logic [31:0]          rdData;
  logic                 unusedWrData;

  assign pins         = {PinUrq, PinIrq};
  assign wrHit        = io.IO_WrEn & io.IO_BlockSelect;
  assign unusedWrData = ^io.IO_WrData;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      plr <= '0;
    end else if (wrHit && (io.IO_RegAddress == ADDR_PLR)) begin
      plr <= io.IO_WrData[NUM_LINES-1:0];
    end
  end

`ifdef EXT_INT_DEBOUNCE_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dbr <= '0;
    end else if (wrHit && (io.IO_RegAddress == ADDR_DBR)) begin
      dbr <= io.IO_WrData[DBC_W-1:0];
    end
  end
`else
  assign dbr = '0;
`endif

  for (genvar g = 0; g < NUM_LINES; g++) begin : gLine
    ext_int_filter_line_debouncer #(.DBC_W(DBC_W)) uLine (
      .Clock    (Clock),
      .Reset    (Reset),
      .pin      (pins[g]),
      .polarity (plr[g]),
      .dbr      (dbr),
      .level    (lineLevel[g])
    );
  end

  assign IntReq    = lineLevel[7:0];
  assign UrgentReq = lineLevel[8];

  always_comb begin
    rdData = '0;
    case (io.IO_RegAddress)
      ADDR_PLR:    rdData[NUM_LINES-1:0] = plr;
`ifdef EXT_INT_DEBOUNCE_EN
      ADDR_DBR:    rdData[DBC_W-1:0] = dbr;
`endif
      ADDR_STATUS: rdData[NUM_LINES-1:0] = lineLevel;
      default:     rdData = '0;
    endcase
  end

  assign io.IO_RdData = rdData;

endmodule

// File: tb/tb_ext_int_filter.sv
// Self-checking bench for ext_int_filter against a run-length reference model.
// Covers both builds; the debounce-specific sequences follow EXT_INT_DEBOUNCE_EN.
module tb_ext_int_filter;
  import ext_int_filter_pkg::*;

`ifdef EXT_INT_DEBOUNCE_EN
  localparam bit DBNC = 1'b1;
`else
  localparam bit DBNC = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] PinIrq;
  logic       PinUrq;
  logic [7:0] IntReq;
  logic       UrgentReq;

  ext_int_filter_if bus ();

  ext_int_filter #(.DBC_W(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .PinIrq    (PinIrq),
    .PinUrq    (PinUrq),
    .io        (bus.slave),
    .IntReq    (IntReq),
    .UrgentReq (UrgentReq)
  );

  always #5 Clock = ~Clock;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: pin delay line, registers, and per-line run length of
  // consecutive conditioned samples that disagree with the filtered output.
  logic [8:0] mS1, mS2, mPlr, mOut;
  logic [7:0] mDbr;
  int         mRun [9];

  typedef struct {
    bit          doWrite;
    bit          sel;
    logic [3:0]  wAddr;
    logic [31:0] data;
    logic [3:0]  rAddr;
    logic [31:0] expRd;
  } regVec_t;

  regVec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mS1 = '0; mS2 = '0; mPlr = '0; mOut = '0; mDbr = '0;
    for (int i = 0; i < 9; i++) mRun[i] = 0;
  endtask

  task automatic modelStep();
    logic [8:0] c;
    if (Reset) begin
      modelReset();
    end else begin
      c = mS2 ^ mPlr;
      for (int i = 0; i < 9; i++) begin
`ifdef EXT_INT_DEBOUNCE_EN
        if (c[i] != mOut[i]) begin
          mRun[i]++;
          if (mRun[i] >= int'(mDbr) + 2) begin
            mOut[i] = c[i];
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
`else
        mOut[i] = c[i];
`endif
      end
      mS2 = mS1;
      mS1 = {PinUrq, PinIrq};
      if (bus.IO_WrEn && bus.IO_BlockSelect) begin
        if (bus.IO_RegAddress == ADDR_PLR) mPlr = bus.IO_WrData[8:0];
        if (bus.IO_RegAddress == ADDR_DBR && DBNC) mDbr = bus.IO_WrData[7:0];
      end
    end
  endtask

  task automatic cyc();
    modelStep();
    @(posedge Clock);
    #1;
    chk("cycleOut", {23'd0, UrgentReq, IntReq}, {23'd0, mOut});
  endtask

  task automatic regWrite(input logic [3:0] addr, input logic [31:0] data);
    bus.IO_WrEn        = 1'b1;
    bus.IO_BlockSelect = 1'b1;
    bus.IO_RegAddress  = addr;
    bus.IO_WrData      = data;
    cyc();
    bus.IO_WrEn        = 1'b0;
    bus.IO_BlockSelect = 1'b0;
  endtask

  task automatic doReset();
    PinIrq = '0;
    PinUrq = 1'b0;
    Reset  = 1'b1;
    cyc();
    Reset  = 1'b0;
  endtask

  function automatic logic [31:0] expRead(input logic [3:0] addr);
    case (addr)
      ADDR_PLR:    return {23'd0, mPlr};
      ADDR_DBR:    return DBNC ? {24'd0, mDbr} : 32'd0;
      ADDR_STATUS: return {23'd0, mOut};
      default:     return 32'd0;
    endcase
  endfunction

  initial begin
    logic seen;
    logic [3:0] ra;
    int ln;

    Reset = 1'b1; PinIrq = '0; PinUrq = 1'b0;
    bus.IO_WrEn = 1'b0; bus.IO_BlockSelect = 1'b0;
    bus.IO_RegAddress = '0; bus.IO_WrData = '0;
    modelReset();

    tbl[0] = '{1'b1, 1'b1, ADDR_PLR,    32'hFFFF_FE5A, ADDR_PLR, 32'h0000_005A};
    tbl[1] = '{1'b1, 1'b1, ADDR_DBR,    32'hABCD_EF37, ADDR_DBR, DBNC ? 32'h37 : 32'h0};
    tbl[2] = '{1'b1, 1'b0, ADDR_PLR,    32'h0000_01FF, ADDR_PLR, 32'h0000_005A};
    tbl[3] = '{1'b1, 1'b1, 4'h7,        32'hFFFF_FFFF, 4'h7,     32'h0};
    tbl[4] = '{1'b1, 1'b1, ADDR_STATUS, 32'hFFFF_FFFF, ADDR_DBR, DBNC ? 32'h37 : 32'h0};
    tbl[5] = '{1'b1, 1'b1, 4'hF,        32'h0,         ADDR_PLR, 32'h0000_005A};
    tbl[6] = '{1'b1, 1'b1, ADDR_PLR,    32'h0,         ADDR_PLR, 32'h0};
    tbl[7] = '{1'b1, 1'b0, ADDR_DBR,    32'h11,        ADDR_DBR, DBNC ? 32'h37 : 32'h0};
    tbl[8] = '{1'b1, 1'b1, ADDR_DBR,    32'h100,       ADDR_DBR, 32'h0};
    tbl[9] = '{1'b0, 1'b0, 4'h0,        32'h0,         4'h3,     32'h0};

    cyc();
    doReset();
    chk("resetIntReq", {24'd0, IntReq}, 32'h0);
    chk("resetUrgent", {31'd0, UrgentReq}, 32'h0);
    bus.IO_RegAddress = ADDR_STATUS; #1;
    chk("resetStatus", bus.IO_RdData, 32'h0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].doWrite) begin
        bus.IO_WrEn        = 1'b1;
        bus.IO_BlockSelect = tbl[i].sel;
        bus.IO_RegAddress  = tbl[i].wAddr;
        bus.IO_WrData      = tbl[i].data;
        cyc();
        bus.IO_WrEn        = 1'b0;
        bus.IO_BlockSelect = 1'b0;
      end
      bus.IO_RegAddress = tbl[i].rAddr;
      #1;
      chk($sformatf("regVec%0d", i), bus.IO_RdData, tbl[i].expRd);
    end

`ifdef EXT_INT_DEBOUNCE_EN
    // Held rise on IRQ2 with DBR=5 lands on the 9th edge.
    doReset();
    regWrite(ADDR_DBR, 32'd5);
    PinIrq = 8'h04;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k < 9) chk("rise9Wait", {23'd0, UrgentReq, IntReq}, 32'h0);
      else       chk("rise9Edge", {23'd0, UrgentReq, IntReq}, 32'h004);
    end

    // 3-cycle pulse must be rejected.
    doReset();
    regWrite(ADDR_DBR, 32'd5);
    seen = 1'b0;
    PinIrq = 8'h01;
    for (int k = 0; k < 3; k++) begin cyc(); seen |= IntReq[0]; end
    PinIrq = 8'h00;
    for (int k = 0; k < 15; k++) begin cyc(); seen |= IntReq[0]; end
    chk("shortPulse", {31'd0, seen}, 32'h0);

    // Active-low urgent pin: idle high stays inactive, low asserts after DBR+4 edges.
    doReset();
    regWrite(ADDR_DBR, 32'd5);
    PinUrq = 1'b1;
    regWrite(ADDR_PLR, 32'h100);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin cyc(); seen |= UrgentReq; end
    chk("urgIdle", {31'd0, seen}, 32'h0);
    PinUrq = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk($sformatf("urgLow%0d", k), {31'd0, UrgentReq}, (k == 9) ? 32'h1 : 32'h0);
    end

    // DBR lowered below a running count completes on the following edge.
    doReset();
    regWrite(ADDR_DBR, 32'd200);
    PinIrq = 8'h02;
    for (int k = 0; k < 53; k++) cyc();
    regWrite(ADDR_DBR, 32'd10);
    chk("dbrLowerBefore", {24'd0, IntReq}, 32'h0);
    cyc();
    chk("dbrLowerAfter", {24'd0, IntReq}, 32'h02);
`else
    // Plain path: three-edge latency, DBR absent.
    doReset();
    PinIrq = 8'h80;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("plain%0d", k), {24'd0, IntReq}, (k == 3) ? 32'h80 : 32'h0);
    end
    regWrite(ADDR_DBR, 32'h55);
    bus.IO_RegAddress = ADDR_DBR; #1;
    chk("dbrAbsent", bus.IO_RdData, 32'h0);
`endif

    // Reset while all IRQ lines are active.
    doReset();
    regWrite(ADDR_DBR, 32'd0);
    PinIrq = 8'hFF;
    for (int k = 0; k < 6; k++) cyc();
    chk("allHigh", {24'd0, IntReq}, 32'hFF);
    Reset = 1'b1;
    cyc();
    chk("resetMid", {24'd0, IntReq}, 32'h0);
    bus.IO_RegAddress = ADDR_STATUS; #1;
    chk("resetMidStatus", bus.IO_RdData, 32'h0);
    Reset = 1'b0;
    PinIrq = 8'h00;

    // Randomized traffic against the model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) begin
        ln = $urandom_range(8);
        if (ln == 8) PinUrq = ~PinUrq;
        else         PinIrq[ln] = ~PinIrq[ln];
      end
      if ($urandom_range(39) == 0) begin
        regWrite(ADDR_DBR, 32'($urandom_range(6)));
      end else if ($urandom_range(99) == 0) begin
        regWrite(ADDR_PLR, 32'($urandom_range(511)));
      end else if ($urandom_range(499) == 0) begin
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
      end else begin
        cyc();
      end
      ra = 4'($urandom_range(4));
      bus.IO_RegAddress = ra;
      #1;
      chk("randRead", bus.IO_RdData, expRead(ra));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
